// File: rtl/crc32_pkg.sv
// Shared definitions for the streaming CRC-32 engine.
//   - Reflected polynomial, residue and standard init/xor-out constants
//   - FSM state type
//   - crc32_byte(): one-byte reflected CRC-32 update, bit-serial, no table
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE    = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_INIT_STD   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT_STD = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } crc32_state_e;

    // Fold one byte into the register, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational single-byte CRC-32 update stage.
//   crc_i  : register value before this byte
//   data_i : byte to fold
//   crc_o  : register value after this byte
module crc32_byte_step
    import crc32_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_byte(crc_i, data_i);

endmodule

// File: rtl/crc32_stream.sv
// Streaming reflected CRC-32 engine with valid/ready input beats and a held
// per-frame result.
// Optional feature macro: CRC32_RESIDUE_CHECK_EN (enables the crc_ok residue
// comparator; without it crc_ok is tied low).
// Ports:
//   clock, reset_n                         clock, async active-low reset
//   in_valid/in_ready/in_data              input beat handshake and bytes
//   in_sof/in_eof/in_last_bytes            frame delimiters, eof byte count-1
//   crc_valid/crc_ready/crc_value/crc_ok   held per-frame result
//   drop_pulse                             beat outside a frame was discarded
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int unsigned    DATA_W  = 32,
    parameter logic [31:0]    INIT    = CRC32_INIT_STD,
    parameter logic [31:0]    XOR_OUT = CRC32_XOROUT_STD,
    parameter logic [31:0]    RESIDUE = CRC32_RESIDUE,
    localparam int unsigned   NB      = DATA_W / 8,
    localparam int unsigned   LB_W    = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [LB_W-1:0]   in_last_bytes,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [31:0]       crc_value,
    output logic              crc_ok,
    output logic              drop_pulse
);

    // Elaboration-time width legality check
    if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_width
        $error("crc32_stream: DATA_W must be 8, 16 or 32");
    end

    crc32_state_e state_q, state_d;
    logic [31:0]  raw_q, raw_d;
    logic         in_ready_q, in_ready_d;
    logic         crc_valid_q, crc_valid_d;
    logic [31:0]  crc_value_q, crc_value_d;
    logic         crc_ok_q, crc_ok_d;
    logic         drop_q, drop_d;

    logic [31:0]  seed;
    logic [31:0]  stage_out [NB];
    logic [31:0]  eof_crc;
    logic [31:0]  fold;
    logic         accept;
    logic         frame_end;
    logic         ok_on_eof;

    // A sof beat restarts the chain from INIT regardless of any partial frame
    assign seed = in_sof ? INIT : raw_q;

    // Byte chain: byte 0 (in_data[7:0]) is folded first
    for (genvar b = 0; b < NB; b++) begin : g_byte
        logic [31:0] c_in;
        logic [31:0] c_out;
        if (b == 0) begin : g_first
            assign c_in = seed;
        end else begin : g_next
            assign c_in = g_byte[b-1].c_out;
        end
        crc32_byte_step u_step (
            .crc_i  (c_in),
            .data_i (in_data[8*b +: 8]),
            .crc_o  (c_out)
        );
        assign stage_out[b] = c_out;
    end

    // On eof beats only bytes 0..in_last_bytes count
    if (NB == 1) begin : g_eof_single
        logic unused_lb;
        assign unused_lb = ^in_last_bytes;
        assign eof_crc   = stage_out[0];
    end else begin : g_eof_mux
        assign eof_crc = stage_out[in_last_bytes];
    end

    assign fold   = in_eof ? eof_crc : stage_out[NB-1];
    assign accept = in_valid & in_ready_q;

`ifdef CRC32_RESIDUE_CHECK_EN
    assign ok_on_eof = (fold == RESIDUE);
`else
    logic [31:0] unused_residue;
    assign unused_residue = RESIDUE;
    assign ok_on_eof      = 1'b0;
`endif

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        raw_d       = raw_q;
        crc_valid_d = crc_valid_q;
        crc_value_d = crc_value_q;
        crc_ok_d    = crc_ok_q;
        drop_d      = 1'b0;
        frame_end   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        raw_d = fold;
                        if (in_eof) frame_end = 1'b1;
                        else        state_d   = RUN;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    raw_d = fold;
                    if (in_eof) frame_end = 1'b1;
                end
            end
            DONE: begin
                if (crc_valid_q && crc_ready) begin
                    state_d     = IDLE;
                    crc_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            state_d     = DONE;
            crc_valid_d = 1'b1;
            crc_value_d = fold ^ XOR_OUT;
            crc_ok_d    = ok_on_eof;
        end

        in_ready_d = (state_d != DONE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            raw_q       <= INIT;
            in_ready_q  <= 1'b1;
            crc_valid_q <= 1'b0;
            crc_value_q <= 32'h0;
            crc_ok_q    <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            raw_q       <= raw_d;
            in_ready_q  <= in_ready_d;
            crc_valid_q <= crc_valid_d;
            crc_value_q <= crc_value_d;
            crc_ok_q    <= crc_ok_d;
            drop_q      <= drop_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign crc_valid  = crc_valid_q;
    assign crc_value  = crc_value_q;
    assign crc_ok     = crc_ok_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream: 32-bit instance checked every cycle against a
// frame-level model, plus an 8-bit legacy raw-mode instance.
module tb_crc32_stream;

    typedef logic [7:0] bq_t[$];

    localparam logic [31:0] M_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] M_XOR  = 32'hFFFFFFFF;
    localparam logic [31:0] M_RES  = 32'hDEBB20E3;
`ifdef CRC32_RESIDUE_CHECK_EN
    localparam bit FEAT_OK = 1'b1;
`else
    localparam bit FEAT_OK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        in_valid, in_ready, in_sof, in_eof, crc_valid, crc_ready, crc_ok, drop_pulse;
    logic [31:0] in_data, crc_value;
    logic [1:0]  in_last_bytes;

    logic        l_in_valid, l_in_ready, l_in_sof, l_in_eof, l_crc_valid, l_crc_ready, l_crc_ok, l_drop;
    logic [7:0]  l_in_data;
    logic [0:0]  l_in_last_bytes;
    logic [31:0] l_crc_value;

    int checks = 0;
    int errors = 0;

    crc32_stream #(.DATA_W(32)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sof(in_sof), .in_eof(in_eof), .in_last_bytes(in_last_bytes),
        .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_value(crc_value),
        .crc_ok(crc_ok), .drop_pulse(drop_pulse)
    );

    crc32_stream #(.DATA_W(8), .INIT(32'h0), .XOR_OUT(32'h0)) u_leg (
        .clock(clock), .reset_n(reset_n),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
        .in_sof(l_in_sof), .in_eof(l_in_eof), .in_last_bytes(l_in_last_bytes),
        .crc_valid(l_crc_valid), .crc_ready(l_crc_ready), .crc_value(l_crc_value),
        .crc_ok(l_crc_ok), .drop_pulse(l_drop)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference CRC: textbook reflected LFSR, one message bit at a time
    function automatic logic [31:0] ref_crc(input logic [31:0] init, input bq_t q);
        logic [31:0] c;
        bit fb;
        c = init;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // One beat on the 32-bit port; called and returns at posedge+1
    task automatic beat(input logic [31:0] d, input bit s, input bit e, input logic [1:0] lb);
        bit rdy;
        int t;
        in_data = d; in_sof = s; in_eof = e; in_last_bytes = lb; in_valid = 1'b1;
        t = 0;
        rdy = 1'b0;
        while (!rdy) begin
            @(negedge clock);
            rdy = in_ready;
            sync();
            t++;
            if (!rdy && t > 200) begin
                checks++; errors++;
                $display("FAIL beat_accept: actual=not_accepted required=accepted at %0t", $time);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input bq_t q, input bit sof, input bit eof);
        int n, idx, cnt;
        logic [31:0] d;
        bit last;
        n = q.size();
        idx = 0;
        while (idx < n) begin
            cnt  = (n - idx > 4) ? 4 : n - idx;
            d    = $urandom();
            for (int k = 0; k < cnt; k++) d[8*k +: 8] = q[idx + k];
            last = (idx + cnt == n);
            beat(d, sof && (idx == 0), eof && last,
                 (eof && last) ? 2'(cnt - 1) : 2'($urandom_range(0, 3)));
            idx += cnt;
        end
    endtask

    task automatic wait_result(input string nm, output logic [31:0] v, output logic ok);
        int t;
        bit got;
        t = 0; got = 1'b0; v = 32'h0; ok = 1'b0;
        while (!got && t < 200) begin
            @(negedge clock);
            if (crc_valid) begin
                got = 1'b1; v = crc_value; ok = crc_ok;
            end
            t++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: actual=no_crc_valid required=crc_valid at %0t", nm, $time);
        end
        sync();
    endtask

    task automatic lbeat(input logic [7:0] d, input bit s, input bit e);
        bit rdy;
        int t;
        l_in_data = d; l_in_sof = s; l_in_eof = e; l_in_valid = 1'b1;
        t = 0; rdy = 1'b0;
        while (!rdy && t < 200) begin
            @(negedge clock);
            rdy = l_in_ready;
            sync();
            t++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL leg_beat_accept: actual=not_accepted required=accepted at %0t", $time);
        end
        l_in_valid = 1'b0;
    endtask

    task automatic l_frame(input string nm, input bq_t q, input logic [31:0] exp);
        int t;
        bit got;
        logic [31:0] v;
        foreach (q[i]) lbeat(q[i], i == 0, i == q.size() - 1);
        t = 0; got = 1'b0; v = 32'h0;
        while (!got && t < 50) begin
            @(negedge clock);
            if (l_crc_valid) begin got = 1'b1; v = l_crc_value; end
            t++;
        end
        chk(nm, v, exp);
        sync();
    endtask

    // Frame-level model and per-cycle compare of the 32-bit instance
    bq_t         m_bytes;
    bit          m_pending, m_inframe;
    bit          e_valid, e_ok, e_drop;
    logic [31:0] e_value, m_raw;
    int          m_nb;

    always @(negedge clock) begin
        if (!reset_n) begin
            m_pending = 1'b0; m_inframe = 1'b0; m_bytes.delete();
            e_valid = 1'b0; e_value = 32'h0; e_ok = 1'b0; e_drop = 1'b0;
        end
        chk("in_ready",   32'(in_ready),   32'(!m_pending));
        chk("crc_valid",  32'(crc_valid),  32'(e_valid));
        chk("crc_value",  crc_value,       e_value);
        chk("crc_ok",     32'(crc_ok),     32'(e_ok));
        chk("drop_pulse", 32'(drop_pulse), 32'(e_drop));
        if (reset_n) begin
            e_drop = 1'b0;
            if (m_pending) begin
                if (crc_ready) begin m_pending = 1'b0; e_valid = 1'b0; end
            end else if (in_valid) begin
                if (in_sof) begin m_bytes.delete(); m_inframe = 1'b1; end
                if (m_inframe) begin
                    m_nb = in_eof ? int'(in_last_bytes) + 1 : 4;
                    for (int k = 0; k < m_nb; k++) m_bytes.push_back(in_data[8*k +: 8]);
                    if (in_eof) begin
                        m_raw     = ref_crc(M_INIT, m_bytes);
                        e_value   = m_raw ^ M_XOR;
                        e_ok      = FEAT_OK && (m_raw == M_RES);
                        e_valid   = 1'b1;
                        m_pending = 1'b1;
                        m_inframe = 1'b0;
                    end
                end else begin
                    e_drop = 1'b1;
                end
            end
        end
    end

    bit rand_on;

    initial begin
        bq_t         q;
        logic [31:0] v, exp4, raw;
        logic        ok;
        int          len;

        in_valid = 0; in_data = 0; in_sof = 0; in_eof = 0; in_last_bytes = 0; crc_ready = 1;
        l_in_valid = 0; l_in_data = 0; l_in_sof = 0; l_in_eof = 0; l_in_last_bytes = 0; l_crc_ready = 1;
        rand_on = 0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready",  32'(in_ready),   32'h1);
        chk("rst_crc_valid", 32'(crc_valid),  32'h0);
        chk("rst_crc_value", crc_value,       32'h0);
        chk("rst_crc_ok",    32'(crc_ok),     32'h0);
        chk("rst_drop",      32'(drop_pulse), 32'h0);
        reset_n = 1'b1;

        // Pin the model against known check values
        chk("model_check",  ref_crc(M_INIT, str2q("123456789")) ^ M_XOR, 32'hCBF43926);
        q = {8'h01};
        chk("model_legacy", ref_crc(32'h0, q), 32'h77073096);

        // Three beats "1234","5678","9"
        send_bytes(str2q("123456789"), 1, 1);
        wait_result("t1", v, ok);
        chk("t1_crc", v, 32'hCBF43926);

        // Legacy 8-bit raw mode
        q = {8'h01};
        l_frame("t2_legacy_01", q, 32'h77073096);
        l_frame("t2_legacy_str", str2q("123456789"), ref_crc(32'h0, str2q("123456789")));

        // 64-byte frame plus its FCS, little-endian
        q = rand_bytes(64);
        raw = ref_crc(M_INIT, q) ^ M_XOR;
        for (int i = 0; i < 4; i++) q.push_back(raw[8*i +: 8]);
        send_bytes(q, 1, 1);
        wait_result("t3a", v, ok);
        chk("t3_ok_good", 32'(ok), 32'(FEAT_OK));
        q[5] = q[5] ^ 8'h10;
        send_bytes(q, 1, 1);
        wait_result("t3b", v, ok);
        chk("t3_ok_bad", 32'(ok), 32'h0);

        // Result backpressure
        crc_ready = 1'b0;
        send_bytes(str2q("ABCD"), 1, 1);
        exp4 = ref_crc(M_INIT, str2q("ABCD")) ^ M_XOR;
        chk("t4_valid_rise", 32'(crc_valid), 32'h1);
        fork
            send_bytes(str2q("xyz"), 1, 1);
            begin
                repeat (3) begin
                    @(negedge clock);
                    chk("t4_valid_held", 32'(crc_valid), 32'h1);
                    chk("t4_value_held", crc_value, exp4);
                    chk("t4_in_ready",   32'(in_ready),  32'h0);
                end
                sync();
                crc_ready = 1'b1;
            end
        join
        wait_result("t4", v, ok);
        chk("t4_next", v, ref_crc(M_INIT, str2q("xyz")) ^ M_XOR);

        // Drops outside a frame and restart on sof mid-frame
        send_bytes(rand_bytes(4), 0, 0);
        chk("t5_drop", 32'(drop_pulse), 32'h1);
        send_bytes(rand_bytes(4), 0, 1);
        chk("t5_drop_eof",  32'(drop_pulse), 32'h1);
        chk("t5_no_result", 32'(crc_valid),  32'h0);
        send_bytes(rand_bytes(8), 1, 0);
        send_bytes(str2q("123456789"), 1, 1);
        wait_result("t5", v, ok);
        chk("t5_crc", v, 32'hCBF43926);

        // Async reset mid-frame
        send_bytes(rand_bytes(8), 1, 0);
        reset_n = 1'b0;
        #1;
        chk("t6_in_ready",  32'(in_ready),   32'h1);
        chk("t6_crc_valid", 32'(crc_valid),  32'h0);
        chk("t6_crc_value", crc_value,       32'h0);
        chk("t6_crc_ok",    32'(crc_ok),     32'h0);
        chk("t6_drop",      32'(drop_pulse), 32'h0);
        repeat (2) sync();
        reset_n = 1'b1;
        send_bytes(str2q("123456789"), 1, 1);
        wait_result("t6", v, ok);
        chk("t6_crc", v, 32'hCBF43926);

        // Randomized frames with result backpressure
        rand_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    if ($urandom_range(0, 4) == 0) send_bytes(rand_bytes(4), 0, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 5) == 0) send_bytes(rand_bytes(4 * $urandom_range(1, 2)), 1, 0);
                    len = $urandom_range(1, 24);
                    send_bytes(rand_bytes(len), 1, 1);
                    repeat ($urandom_range(0, 2)) sync();
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    sync();
                    crc_ready = ($urandom_range(0, 3) != 0);
                end
                crc_ready = 1'b1;
            end
        join
        repeat (5) sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
